// File: rtl/binary_grant_decoder.sv
`timescale 1ns/1ps
// Registered binary-to-one-hot grant decoder, released by ack or hold timeout.
// Optional macro BINARY_GRANT_DECODER_ERR_CNT_EN builds the saturating error counter.
module binary_grant_decoder #(
  parameter  int WIDTH      = 5,
  parameter  int HOLD_MAX   = 15,
  localparam int ADDR_WIDTH = $clog2(WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_enable,
  input  logic [ADDR_WIDTH-1:0] iv_addr,
  output logic [WIDTH-1:0]      ov_grant,
  output logic                  o_grant_valid,
  input  logic                  i_ack,
  output logic                  o_timeout,
  output logic                  o_range_err,
  output logic [7:0]            ov_err_count
);

  localparam int CW = $clog2(HOLD_MAX + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             range_err_q, range_err_d;
  logic             accept;
  logic             in_range;
  logic             expire;

  assign accept   = i_valid & o_ready;
  assign in_range = int'(iv_addr) < WIDTH;
  assign expire   = cnt_q == CW'(HOLD_MAX - 1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      range_err_q <= range_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
    range_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && i_enable) begin
          if (in_range) begin
            state_d = GRANT;
            grant_d = WIDTH'(1) << iv_addr;
            cnt_d   = '0;
          end else begin
            range_err_d = 1'b1;
          end
        end
      end
      GRANT: begin
        // ack takes priority over an expiry in the same cycle
        if (i_ack) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (expire) begin
          state_d   = IDLE;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    o_ready       = i_rst_n & (state_q == IDLE);
    o_grant_valid = state_q == GRANT;
    ov_grant      = grant_q;
    o_timeout     = timeout_q;
    o_range_err   = range_err_q;
  end

`ifdef BINARY_GRANT_DECODER_ERR_CNT_EN
  logic [7:0] err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= '0;
    end else if ((timeout_d | range_err_d) && err_q != 8'hFF) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign ov_err_count = err_q;
`else
  assign ov_err_count = 8'd0;
`endif

endmodule
